// File: rtl/jsv_pio_pkg.sv
// Shared constants for the key/switch PIO: Avalon register addresses and
// edge-detect encodings.
package jsv_pio_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/jsv_key_debounce.sv
// One-bit debounce filter: the output follows the synchronised input only
// after it has disagreed with the held value for DEBOUNCE_CYCLES cycles.
module jsv_key_debounce
   import jsv_pio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_sync,
   output logic o_level
);

   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic        r_stable;
   logic [15:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else if (i_sync == r_stable) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_stable <= i_sync;
         r_cnt    <= '0;
      end else begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   assign o_level = r_stable;

endmodule

// File: rtl/jsv_key_pio.sv
// Avalon-MM key/switch input port with synchroniser, edge capture (W1C),
// interrupt mask and level irq. Debounce is compiled in with JSV_KEY_PIO_DEBOUNCE_EN.
module jsv_key_pio
   import jsv_pio_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int EDGE_TYPE       = 1,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   logic [WIDTH-1:0] w_sync_in;
   logic [WIDTH-1:0] w_level;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] w_edge_raw;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_edge_cap;
   logic [WIDTH-1:0] w_clr;
   logic [16:0]      r_settle;
   logic             w_settled;
   logic             w_wr;
   logic [31:0]      w_rd_mux;
   logic [31:0]      r_readdata;
   logic             r_irq;

`ifdef JSV_KEY_PIO_DEBOUNCE_EN
   localparam int SETTLE = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;

   for (genvar g = 0; g < WIDTH; g++) begin : g_db
      jsv_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk     (clk),
         .reset_n (reset_n),
         .i_sync  (w_sync_in[g]),
         .o_level (w_level[g])
      );
   end
`else
   localparam int SETTLE = SYNC_STAGES + 1;

   assign w_level = w_sync_in;
   wire [15:0] w_unused_dc = 16'(DEBOUNCE_CYCLES);
`endif

   wire w_unused_wdata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
   end
   assign w_sync_in = r_sync[SYNC_STAGES-1];

   // Reset values in the synchroniser/prev flops look like edges; gate them out
   // until the pipeline has filled with real pin values.
   assign w_settled = (r_settle == 17'(SETTLE));
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        r_settle <= '0;
      else if (!w_settled) r_settle <= r_settle + 17'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_prev <= '0;
      else          r_prev <= w_level;
   end

   always_comb begin
      w_edge_raw = '0;
      case (EDGE_TYPE)
         EDGE_RISE: w_edge_raw = w_level & ~r_prev;
         EDGE_FALL: w_edge_raw = ~w_level & r_prev;
         default:   w_edge_raw = w_level ^ r_prev;
      endcase
   end
   assign w_edge = w_settled ? w_edge_raw : '0;

   // Avalon slave without wait states: a write is accepted in any cycle with
   // chipselect=1 and write_n=0; readdata is valid one cycle after address.
   assign w_wr  = chipselect && !write_n;
   assign w_clr = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mask     <= '0;
         r_edge_cap <= '0;
      end else begin
         if (w_wr && address == ADDR_MASK) r_mask <= writedata[WIDTH-1:0];
         r_edge_cap <= w_edge | (r_edge_cap & ~w_clr);
      end
   end

   always_comb begin
      w_rd_mux = '0;
      case (address)
         ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_level;
         ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_mask;
         ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edge_cap;
         default:   w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_readdata <= w_rd_mux;
         r_irq      <= |(r_edge_cap & r_mask);
      end
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule
